ahb_slave_mem: RTL
==================

// Module: ahb_slave_mem
// PURPOSE
// - AHB-Lite responder: the target end of the single read/write AHB master driver.
// - Decodes address/data phases, inserts programmable wait states and returns OKAY/ERROR.
// - Backs transfers with a small byte-addressable register memory.
// - Sits behind the AHB agent in the subsystem bench as the DUT-side slave model, and is synthesizable.
// PARAMETERS
// - DEPTH        16  number of 32-bit words; legal byte addresses 0 .. DEPTH*4-1
// - WAIT_STATES   0  HREADYOUT-low cycles at the start of every data phase (0..15)
// PORTS
// - HCLK       in   1   clock; all flops on posedge
// - HRESETn    in   1   asynchronous active-low reset
// - HSEL       in   1   slave select (address phase)
// - HADDR      in  32   byte address
// - HTRANS     in   2   IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
// - HWRITE     in   1   1=write, 0=read
// - HSIZE      in   3   0=byte, 1=half, 2=word; >2 is illegal
// - HBURST     in   3   ignored (each beat handled independently)
// - HPROT      in   4   ignored
// - HWDATA     in  32   write data (data phase)
// - HREADY     in   1   bus ready; qualifies address-phase sampling
// - HREADYOUT  out  1   slave ready; low = extend data phase
// - HRESP      out  2   0=OKAY, 1=ERROR
// - HRDATA     out 32   read data, valid when HREADYOUT=1 in a read data phase
// BEHAVIOUR
// - Reset (async, HRESETn low): state=IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, wait counter=0, all memory words=0.
// - Transfer accept: on posedge with HSEL & HREADY & HTRANS[1].
//   - Register HADDR, HWRITE and HSIZE into address-phase regs.
//   - Error flag = (HADDR[31:2] >= DEPTH) | (HSIZE>2) | misaligned (half with HADDR[0]=1; word with HADDR[1:0]!=0).
// - IDLE/BUSY or HSEL=0 with HREADY=1: the next data phase is OKAY, zero-wait, no memory access.
// - FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
//   - IDLE: on accept -> ERR1 if error; else WAIT if WAIT_STATES>0 (counter=WAIT_STATES-1); else DATA.
//   - WAIT: HREADYOUT=0, HRESP=OKAY; counter decrements; at 0 -> DATA.
//   - DATA: HREADYOUT=1, HRESP=OKAY.
//     - Write: commit HWDATA at this edge, byte lanes from HSIZE/HADDR[1:0].
//     - Read: HRDATA=mem[addr_q] (combinational from the array).
//     - Next state is chosen by a new accept this edge (same rules as IDLE); otherwise -> IDLE.
//   - ERR1: HREADYOUT=0, HRESP=ERROR; -> ERR2 unconditionally.
//   - ERR2: HREADYOUT=1, HRESP=ERROR; no memory write; same accept rules as DATA.
// - Address phase is only sampled when HREADY=1, so a new transfer cannot be accepted in WAIT or ERR1.
// - Latency:
//   - WAIT_STATES=0: one-cycle data phase; back-to-back NONSEQ complete one per cycle.
//   - Otherwise the data phase lasts WAIT_STATES+1 cycles.
//   - ERROR always takes 2 cycles regardless of WAIT_STATES.
// - HRDATA is 0 outside a read DATA cycle, including error and write phases.
// - Read immediately after a write to the same word returns the new data; the write commits before the read data phase.
// - Byte lanes are little-endian (lane n = HADDR[1:0]==n); a byte write leaves the other lanes unchanged.
// - Reset mid-transfer aborts: no partial write, outputs take reset values immediately.
// STRUCTURE
// - Shared constants come from ahb_agent_pkg: AHB_IDLE/BUSY/NON_SEQ/SEQ, AHB_READ/WRITE, and AHB_OKAY/AHB_ERROR (added there).
// - The FSM state enum is local.
// - Sub-module ahb_slave_ram: DEPTH x 32 array, async-reset clear, 4-bit byte-enable write port, combinational read port.
// - Top level holds the FSM, wait counter, address-phase regs, error decode and byte-enable generation.
// TESTING
// - Reset: HRESETn=0 mid-wait -> HREADYOUT=1, HRESP=0, HRDATA=0; a read of 0x0 afterwards returns 0.
// - Word write/read, WAIT_STATES=0: write 0xDEADBEEF @0x8, then read @0x8.
//   -> HRDATA=0xDEADBEEF; HREADYOUT never low; read data phase directly follows the write data phase.
// - Byte write: write 0x11223344 @0x4, then byte write HWDATA=0x00AA0000 @0x6.
//   -> read @0x4 returns 0x11AA3344.
// - Wait states, WAIT_STATES=3: one read -> HREADYOUT low exactly 3 cycles, then high with valid data.
//   -> an address phase presented meanwhile is not sampled until HREADY=1.
// - Error, DEPTH=16: read @0x40 -> cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1, HRDATA=0.
//   -> also: word write @0x2 errors, and memory is unchanged.
// - IDLE/BUSY: HTRANS=1 with HSEL=1 -> OKAY zero-wait, no memory change.
//   -> HSEL=0 with NONSEQ -> ignored.

Source files
------------

// File: rtl/ahb_agent_pkg.sv
// ============================================================================
// Module      : ahb_agent_pkg
// Description : Shared AHB-Lite encodings for the AHB agent and its slave
//               memory model: HTRANS, HWRITE, HRESP and HSIZE values plus a
//               helper for the transfer-active test and little-endian
//               byte-lane enables.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_agent_pkg;

  // HTRANS encodings
  localparam logic [1:0] AHB_IDLE    = 2'b00;
  localparam logic [1:0] AHB_BUSY    = 2'b01;
  localparam logic [1:0] AHB_NON_SEQ = 2'b10;
  localparam logic [1:0] AHB_SEQ     = 2'b11;

  // HWRITE encodings
  localparam logic AHB_READ  = 1'b0;
  localparam logic AHB_WRITE = 1'b1;

  // HRESP encodings
  localparam logic [1:0] AHB_OKAY  = 2'b00;
  localparam logic [1:0] AHB_ERROR = 2'b01;

  // HSIZE encodings supported by the slave; anything larger is illegal
  localparam logic [2:0] AHB_SIZE_BYTE = 3'd0;
  localparam logic [2:0] AHB_SIZE_HALF = 3'd1;
  localparam logic [2:0] AHB_SIZE_WORD = 3'd2;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never do.
  function automatic logic ahb_is_active(input logic [1:0] trans);
    logic active;
    case (trans)
      AHB_NON_SEQ, AHB_SEQ: active = 1'b1;
      AHB_IDLE,    AHB_BUSY: active = 1'b0;
      default:              active = 1'b0;
    endcase
    return active;
  endfunction

  // Little-endian lane enables: lane n carries the byte at address offset n.
  function automatic logic [3:0] ahb_byte_en(input logic [2:0] size,
                                             input logic [1:0] offs);
    logic [3:0] be;
    case (size)
      AHB_SIZE_BYTE: be = 4'b0001 << offs;
      AHB_SIZE_HALF: be = offs[1] ? 4'b1100 : 4'b0011;
      AHB_SIZE_WORD: be = 4'b1111;
      default:       be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage : ahb_agent_pkg

`default_nettype wire

// File: rtl/ahb_slave_ram.sv
// ============================================================================
// Module      : ahb_slave_ram
// Description : DEPTH x 32-bit register memory behind the AHB slave. Every
//               word is cleared by the asynchronous reset. One write port with
//               per-byte enables and one combinational read port share a
//               single word address.
// Ports       : clk    - clock, posedge
//               rst_n  - asynchronous active-low reset (clears all words)
//               be     - byte-lane write enables (lane n = bits 8n+7:8n)
//               addr   - word address for both write and read
//               wdata  - write data, only enabled lanes are stored
//               rdata  - combinational read data of mem[addr]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_slave_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // Storage is split per byte lane so that each lane has a single writer and
  // a partial write never touches the other lanes.
  for (genvar gl = 0; gl < 4; gl++) begin : g_lane
    logic [7:0] r_lane [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int w = 0; w < DEPTH; w++) begin
          r_lane[w] <= 8'h00;
        end
      end else if (be[gl]) begin
        r_lane[addr] <= wdata[gl*8 +: 8];
      end
    end

    assign rdata[gl*8 +: 8] = r_lane[addr];
  end

endmodule : ahb_slave_ram

`default_nettype wire

// File: rtl/ahb_slave_mem.sv
// ============================================================================
// Module      : ahb_slave_mem
// Description : AHB-Lite responder backed by a small byte-addressable memory.
//               Decodes the address phase, inserts WAIT_STATES wait cycles at
//               the start of every good data phase, and answers illegal
//               transfers (out of range, HSIZE>2, misaligned) with a two-cycle
//               ERROR response that never touches memory.
// Ports       : HCLK      - clock, posedge
//               HRESETn   - asynchronous active-low reset
//               HSEL      - slave select (address phase)
//               HADDR     - byte address
//               HTRANS    - transfer type (IDLE/BUSY/NONSEQ/SEQ)
//               HWRITE    - 1 = write, 0 = read
//               HSIZE     - 0 byte, 1 half, 2 word; larger is illegal
//               HBURST    - unused, each beat is handled on its own
//               HPROT     - unused
//               HWDATA    - write data (data phase)
//               HREADY    - bus ready, qualifies address-phase sampling
//               HREADYOUT - slave ready, low extends the data phase
//               HRESP     - 0 OKAY, 1 ERROR
//               HRDATA    - read data, zero outside a read data cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_slave_mem
  import ahb_agent_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The wait counter is loaded with WAIT_STATES-1 so that WAIT lasts exactly
  // WAIT_STATES cycles before the single ready DATA cycle.
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_wait_cnt;
  logic [3:0]    w_wait_cnt_nxt;

  // Address-phase registers
  logic [AW+1:0] r_addr;
  logic          r_write;
  logic [2:0]    r_size;

  logic          w_accept;
  logic          w_slot_open;
  logic          w_addr_err;
  logic [3:0]    w_byte_en;
  logic [31:0]   w_rdata;

  // Burst and protection attributes carry no meaning for this memory.
  logic          w_unused;
  assign w_unused = ^{HBURST, HPROT};

  // ---------------------------------------------------------------------------
  // Address-phase decode
  // ---------------------------------------------------------------------------
  assign w_accept = HSEL & HREADY & ahb_is_active(HTRANS);

  // Only the ready cycles of a data phase can overlap a new address phase.
  // This keeps the captured address stable even if HREADY is not looped back.
  assign w_slot_open = (r_state == ST_IDLE) || (r_state == ST_DATA) ||
                       (r_state == ST_ERR2);

  assign w_addr_err = ({2'b00, HADDR[31:2]} >= 32'(DEPTH))                  |
                      (HSIZE > AHB_SIZE_WORD)                               |
                      ((HSIZE == AHB_SIZE_HALF) && HADDR[0])                |
                      ((HSIZE == AHB_SIZE_WORD) && (HADDR[1:0] != 2'b00));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr  <= '0;
      r_write <= AHB_READ;
      r_size  <= AHB_SIZE_BYTE;
    end else if (w_accept && w_slot_open) begin
      r_addr  <= HADDR[AW+1:0];
      r_write <= HWRITE;
      r_size  <= HSIZE;
    end
  end

  // ---------------------------------------------------------------------------
  // Data-phase FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      // Ready states: the data phase (if any) completes this edge, so the
      // next state depends only on whether a new transfer is accepted.
      ST_IDLE, ST_DATA, ST_ERR2: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (w_addr_err) begin
            w_state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt    = ST_WAIT;
            w_wait_cnt_nxt = WAIT_INIT;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        w_state_nxt = ST_ERR2;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Response outputs follow the state directly; the IDLE defaults are also
  // the reset values.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = AHB_OKAY;
    case (r_state)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = AHB_ERROR;
      end
      ST_ERR2: begin
        HRESP = AHB_ERROR;
      end
      default: begin
        HREADYOUT = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory access
  // ---------------------------------------------------------------------------
  // A write commits on the edge that closes its DATA cycle, so a read issued
  // back-to-back sees the new value in its own data phase.
  assign w_byte_en = ((r_state == ST_DATA) && (r_write == AHB_WRITE)) ?
                     ahb_byte_en(r_size, r_addr[1:0]) : 4'b0000;

  ahb_slave_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .be    (w_byte_en),
    .addr  (r_addr[AW+1:2]),
    .wdata (HWDATA),
    .rdata (w_rdata)
  );

  assign HRDATA = ((r_state == ST_DATA) && (r_write == AHB_READ)) ? w_rdata : 32'h0;

endmodule : ahb_slave_mem

`default_nettype wire
